// File: rtl/set_scan_ctrl.sv
// SET scan controller: walks the 8x8 map through one shared membership cell and counts set hits.
// Optional SET_SCAN_SKIP_EN: mode 00 issues circle A only, one cycle per point.
module set_scan_ctrl #(
  parameter int N_POINTS = 64,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [3:0]       ax,
  input  logic [3:0]       ay,
  input  logic [3:0]       ar,
  input  logic [3:0]       bx,
  input  logic [3:0]       by,
  input  logic [3:0]       br,
  output logic [5:0]       cell_now,
  output logic [3:0]       cell_x,
  output logic [3:0]       cell_y,
  output logic [3:0]       cell_r,
  output logic             cell_en,
  input  logic             cell_result,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] candidate
);

  typedef enum logic [2:0] {
    IDLE, SCAN_A, SCAN_B, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [5:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             a_hit;
  logic [1:0]       mode_q;
  logic [3:0]       ax_q, ay_q, ar_q;
  logic [3:0]       bx_q, by_q, br_q;
  logic             skip, last, inc;
  logic             acc_en, a_eff, f_bit;

`ifdef SET_SCAN_SKIP_EN
  assign skip = (mode_q == 2'b00);
`else
  assign skip = 1'b0;
`endif

  assign last      = (idx == 6'(N_POINTS - 1));
  assign candidate = cnt;
  // Skipped scans have no B issue, so the live result is the A hit.
  assign a_eff     = skip ? cell_result : a_hit;

  always_comb begin
    state_nx = state;
    cell_now = '0;
    cell_x   = '0;
    cell_y   = '0;
    cell_r   = '0;
    cell_en  = 1'b0;
    busy     = 1'b0;
    valid    = 1'b0;
    acc_en   = 1'b0;
    inc      = 1'b0;
    f_bit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SCAN_A;
      end
      SCAN_A: begin
        busy     = 1'b1;
        cell_en  = 1'b1;
        cell_now = idx;
        cell_x   = ax_q;
        cell_y   = ay_q;
        cell_r   = ar_q;
        acc_en   = (idx != 6'd0);
        if (!skip) begin
          state_nx = SCAN_B;
        end else if (last) begin
          state_nx = DRAIN;
        end else begin
          inc = 1'b1;
        end
      end
      SCAN_B: begin
        busy     = 1'b1;
        cell_en  = 1'b1;
        cell_now = idx;
        cell_x   = bx_q;
        cell_y   = by_q;
        cell_r   = br_q;
        if (last) begin
          state_nx = DRAIN;
        end else begin
          state_nx = SCAN_A;
          inc      = 1'b1;
        end
      end
      DRAIN: begin
        busy     = 1'b1;
        acc_en   = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        valid    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    unique case (mode_q)
      2'b00:   f_bit = a_eff;
      2'b01:   f_bit = a_eff & cell_result;
      2'b10:   f_bit = a_eff ^ cell_result;
      default: f_bit = a_eff | cell_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      cnt    <= '0;
      a_hit  <= 1'b0;
      mode_q <= '0;
      ax_q   <= '0;
      ay_q   <= '0;
      ar_q   <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      br_q   <= '0;
    end else begin
      if (state == IDLE && start) begin
        idx    <= '0;
        cnt    <= '0;
        mode_q <= mode;
        ax_q   <= ax;
        ay_q   <= ay;
        ar_q   <= ar;
        bx_q   <= bx;
        by_q   <= by;
        br_q   <= br;
      end
      if (state == SCAN_B) a_hit <= cell_result;
      if (inc)             idx   <= idx + 6'd1;
      if (acc_en)          cnt   <= cnt + CNT_W'(f_bit);
    end
  end

endmodule
